halfband_mac_sequencer: RTL and testbench
=========================================

// Module: halfband_mac_sequencer
// PURPOSE
//   Controller for the time-multiplexed half-band decimate-by-2 FIR datapath (one multiplier, one accumulator).
//   Accepts input samples by valid/ready and writes them into the external circular sample RAM.
//   After every 2nd accepted sample, issues one MAC per non-zero tap: even taps plus the centre tap.
//   Then waits for the datapath pipeline and presents one decimated output by valid/ready.
//   Sits between the sample source, the sample RAM/coefficient ROM/MAC datapath and the output sink.
// PARAMETERS
//   N          31  total FIR taps; N%4==3 required (centre tap (N-1)/2 odd); elaboration error otherwise
//   MAC_LAT    2   cycles from last mac_en to accumulator result valid at datapath output
//   AW         5   sample RAM address width; 2**AW >= N+1 required
//   localparam PHASE_TAPS=(N+1)/2 (16), MAC_CYCLES=PHASE_TAPS+1 (17), CW=$clog2(MAC_CYCLES) (5)
// PORTS
//   clk        in   1   clock
//   reset      in   1   synchronous, active-high reset
//   in_valid   in   1   source has a sample (data goes straight to RAM; not routed here)
//   in_ready   out  1   combinational: 1 only in IDLE
//   buf_we     out  1   sample RAM write enable
//   buf_wzero  out  1   RAM write data mux: 1 = write zero (INIT), 0 = input sample
//   buf_waddr  out  AW  RAM write address
//   buf_raddr  out  AW  RAM read address (registered)
//   coef_addr  out  CW  coefficient ROM address (registered); PHASE_TAPS = centre coefficient
//   mac_en     out  1   MAC enable (registered)
//   mac_clr    out  1   with mac_en: load product instead of accumulate (registered)
//   out_valid  out  1   datapath result is valid; held until out_ready
//   out_ready  in   1   sink accepts result
//   busy       out  1   state != IDLE
// BEHAVIOUR
//   Reset: state=INIT, wr_ptr=0, phase=0, buf_raddr=0, coef_addr=0, mac_en=0, mac_clr=0, out_valid=0.
//   Reset mid-operation aborts everything; same values next cycle; no partial output is ever presented.
//   INIT: 2**AW cycles with buf_we=1, buf_wzero=1, buf_waddr=0..2**AW-1; in_ready=0; then IDLE, wr_ptr=0.
//   IDLE: in_ready=1; buf_we=in_valid, buf_waddr=wr_ptr, buf_wzero=0 (combinational).
//     Accept (in_valid & in_ready): wr_ptr+=1 mod 2**AW, phase toggles.
//     Accept with phase==1: latch newest=wr_ptr, go to ACCUM.
//   ACCUM: j=0..MAC_CYCLES-1, one per cycle; mac_en=1 for all j, mac_clr=1 only for j=0.
//     j<PHASE_TAPS: buf_raddr=newest-2j, coef_addr=j.
//     j=PHASE_TAPS: buf_raddr=newest-(N-1)/2, coef_addr=PHASE_TAPS.
//     All address arithmetic is mod 2**AW. After the last j, go to DRAIN.
//   DRAIN: MAC_LAT cycles, mac_en=0; then WAIT_OUT.
//   WAIT_OUT: out_valid=1 until out_valid & out_ready; then out_valid=0, go to IDLE next cycle.
//   No RAM writes outside IDLE/INIT, so the window is never overwritten while being read.
//   Timing: 2nd sample accepted at edge T -> mac_en high T+1..T+MAC_CYCLES -> out_valid from T+MAC_CYCLES+1+MAC_LAT.
//   Continuous in_valid with out_ready=1: one output every 2+MAC_CYCLES+MAC_LAT+1 cycles (22 at defaults).
//   in_valid while in_ready=0 is ignored; the source must hold it.
//   out_ready while out_valid=0 is ignored.
// TESTING
//   Release reset -> 32 cycles buf_we=1, buf_wzero=1, waddr 0..31, in_ready=0; in_ready=1 on cycle 33.
//   2 samples after INIT -> waddr 0,1.
//     Then 17 mac_en cycles: raddr 1,31,29,...,3 then 18; coef_addr 0..16; mac_clr on first only.
//     out_valid 20 cycles after the 2nd accept.
//   out_ready=0 for 10 cycles at out_valid -> out_valid held 11 cycles, in_ready=0, buf_we=0 throughout.
//   40 samples with idle gaps -> waddr wraps 31->0; every ACCUM raddr sequence = newest-2j mod 32.
//   reset pulsed at ACCUM j=5 -> next cycle mac_en=0, out_valid=0, INIT rerun, no out_valid for that pair.
//   in_valid=1 and out_ready=1 held for 220 cycles -> exactly 10 outputs, 22 cycles apart, 2 accepts each.

Source files
------------

// File: rtl/halfband_mac_sequencer_if.sv
// Bus between the half-band MAC sequencer and its surroundings: sample
// source handshake, sample RAM / coefficient ROM addressing, MAC control
// and the decimated-output handshake towards the sink.
interface halfband_mac_sequencer_if #(
    parameter int AW = 5,
    parameter int CW = 5
);
    logic          in_valid;
    logic          in_ready;
    logic          buf_we;
    logic          buf_wzero;
    logic [AW-1:0] buf_waddr;
    logic [AW-1:0] buf_raddr;
    logic [CW-1:0] coef_addr;
    logic          mac_en;
    logic          mac_clr;
    logic          out_valid;
    logic          out_ready;
    logic          busy;

    // Sequencer side: drives RAM/ROM/MAC control and both ready/valid outputs.
    modport master (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output buf_we,
        output buf_wzero,
        output buf_waddr,
        output buf_raddr,
        output coef_addr,
        output mac_en,
        output mac_clr,
        output out_valid,
        output busy
    );

    // Environment side: sample source, datapath and output sink.
    modport slave (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  buf_we,
        input  buf_wzero,
        input  buf_waddr,
        input  buf_raddr,
        input  coef_addr,
        input  mac_en,
        input  mac_clr,
        input  out_valid,
        input  busy
    );
endinterface

// File: rtl/halfband_mac_sequencer.sv
// Controller for a time-multiplexed half-band decimate-by-2 FIR.
// Writes accepted samples into a circular RAM, and after every second
// sample walks the even taps plus the centre tap through a single MAC,
// waits for the MAC pipeline, then offers one decimated output.
module halfband_mac_sequencer #(
    parameter int N       = 31,
    parameter int MAC_LAT = 2,
    parameter int AW      = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    halfband_mac_sequencer_if.master bus
);
    localparam int PHASE_TAPS = (N + 1) / 2;
    localparam int MAC_CYCLES = PHASE_TAPS + 1;
    localparam int CW         = $clog2(MAC_CYCLES);
    // Tap counter must also hold MAC_CYCLES itself (the "done" value).
    localparam int JW         = $clog2(MAC_CYCLES + 1);
    localparam int CENTRE     = (N - 1) / 2;
    localparam int DW         = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    localparam logic [2:0] ST_INIT  = 3'd0;
    localparam logic [2:0] ST_IDLE  = 3'd1;
    localparam logic [2:0] ST_ACCUM = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_WAIT  = 3'd4;

    localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
    localparam logic [AW-1:0] ADDR_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] CENTRE_OFS = AW'(CENTRE);
    localparam logic [JW-1:0] J_ONE     = JW'(1);
    localparam logic [JW-1:0] J_DONE    = JW'(MAC_CYCLES);
    localparam logic [JW-1:0] J_CENTRE  = JW'(PHASE_TAPS);
    localparam logic [DW-1:0] D_ONE     = DW'(1);
    localparam logic [DW-1:0] D_LAST    = DW'(MAC_LAT - 1);

    // Parameter sanity: the centre tap must land on an odd index and the
    // circular buffer must hold a full window plus the incoming sample.
    generate
        if (N % 4 != 3) begin : g_bad_n
            $error("halfband_mac_sequencer: N %% 4 must equal 3");
        end
        if ((1 << AW) < N + 1) begin : g_bad_aw
            $error("halfband_mac_sequencer: 2**AW must be >= N+1");
        end
        if (MAC_LAT < 1) begin : g_bad_lat
            $error("halfband_mac_sequencer: MAC_LAT must be >= 1");
        end
    endgenerate

    logic [2:0]    state_q,     state_d;
    logic [AW-1:0] wr_ptr_q,    wr_ptr_d;
    logic          phase_q,     phase_d;
    logic [AW-1:0] newest_q,    newest_d;
    logic [JW-1:0] j_q,         j_d;
    logic [DW-1:0] drain_q,     drain_d;
    logic [AW-1:0] raddr_q,     raddr_d;
    logic [CW-1:0] coef_q,      coef_d;
    logic          mac_en_q,    mac_en_d;
    logic          mac_clr_q,   mac_clr_d;
    logic          out_valid_q, out_valid_d;

    logic          in_ready_s;
    logic          accept_s;

    // Handshake and RAM write port decode straight from the current state.
    always_comb begin
        in_ready_s = (state_q == ST_IDLE);
        accept_s   = bus.in_valid & in_ready_s;
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.buf_we    = (state_q == ST_INIT) | accept_s;
    assign bus.buf_wzero = (state_q == ST_INIT);
    assign bus.buf_waddr = wr_ptr_q;
    assign bus.buf_raddr = raddr_q;
    assign bus.coef_addr = coef_q;
    assign bus.mac_en    = mac_en_q;
    assign bus.mac_clr   = mac_clr_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = (state_q != ST_IDLE);

    // Next-state logic for the sequencer FSM, pointers and MAC control.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        phase_d     = phase_q;
        newest_d    = newest_q;
        j_d         = j_q;
        drain_d     = drain_q;
        raddr_d     = raddr_q;
        coef_d      = coef_q;
        mac_en_d    = 1'b0;
        mac_clr_d   = 1'b0;
        out_valid_d = out_valid_q;

        case (state_q)
            ST_INIT: begin
                // wr_ptr doubles as the zero-fill address and wraps back to 0.
                wr_ptr_d = wr_ptr_q + ADDR_ONE;
                if (wr_ptr_q == ADDR_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (accept_s) begin
                    wr_ptr_d = wr_ptr_q + ADDR_ONE;
                    phase_d  = ~phase_q;
                    if (phase_q) begin
                        // Second sample of the pair: issue tap 0 on this edge.
                        newest_d  = wr_ptr_q;
                        state_d   = ST_ACCUM;
                        mac_en_d  = 1'b1;
                        mac_clr_d = 1'b1;
                        raddr_d   = wr_ptr_q;
                        coef_d    = '0;
                        j_d       = J_ONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (j_q == J_DONE) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end else begin
                    mac_en_d = 1'b1;
                    coef_d   = CW'(j_q);
                    j_d      = j_q + J_ONE;
                    if (j_q == J_CENTRE) begin
                        raddr_d = newest_q - CENTRE_OFS;
                    end else begin
                        raddr_d = newest_q - AW'({j_q, 1'b0});
                    end
                end
            end
            ST_DRAIN: begin
                if (drain_q == D_LAST) begin
                    state_d     = ST_WAIT;
                    out_valid_d = 1'b1;
                end else begin
                    drain_d = drain_q + D_ONE;
                end
            end
            ST_WAIT: begin
                if (out_valid_q && bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_INIT;
                wr_ptr_d    = '0;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset; reset aborts any operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            wr_ptr_q    <= '0;
            phase_q     <= 1'b0;
            newest_q    <= '0;
            j_q         <= '0;
            drain_q     <= '0;
            raddr_q     <= '0;
            coef_q      <= '0;
            mac_en_q    <= 1'b0;
            mac_clr_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            phase_q     <= phase_d;
            newest_q    <= newest_d;
            j_q         <= j_d;
            drain_q     <= drain_d;
            raddr_q     <= raddr_d;
            coef_q      <= coef_d;
            mac_en_q    <= mac_en_d;
            mac_clr_q   <= mac_clr_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_halfband_mac_sequencer.sv
// Directed bench for halfband_mac_sequencer at default parameters
// (N=31, MAC_LAT=2, AW=5). Inputs change 1 time unit after the rising
// edge and outputs are checked before the next rising edge.
module tb_halfband_mac_sequencer;
    logic clk = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;

    logic [4:0] tb_wr;
    logic       tb_phase;

    always #5 clk = ~clk;

    halfband_mac_sequencer_if #(.AW(5), .CW(5)) bus_if ();

    halfband_mac_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Walk the 32 zero-fill cycles, then confirm the block is idle.
    task automatic run_init();
        for (int k = 0; k < 32; k++) begin
            chk("init_we",        bus_if.buf_we,    32'd1);
            chk("init_wzero",     bus_if.buf_wzero, 32'd1);
            chk("init_waddr",     bus_if.buf_waddr, k);
            chk("init_in_ready",  bus_if.in_ready,  32'd0);
            chk("init_out_valid", bus_if.out_valid, 32'd0);
            chk("init_mac_en",    bus_if.mac_en,    32'd0);
            tick();
        end
        chk("idle_in_ready", bus_if.in_ready, 32'd1);
        chk("idle_busy",     bus_if.busy,     32'd0);
        chk("idle_we",       bus_if.buf_we,   32'd0);
        tb_wr    = 5'd0;
        tb_phase = 1'b0;
    endtask

    // Offer one sample in IDLE; it must be written at the expected address.
    task automatic accept();
        bus_if.in_valid = 1'b1;
        #1;
        chk("acc_in_ready", bus_if.in_ready,  32'd1);
        chk("acc_we",       bus_if.buf_we,    32'd1);
        chk("acc_wzero",    bus_if.buf_wzero, 32'd0);
        chk("acc_waddr",    bus_if.buf_waddr, tb_wr);
        tick();
        bus_if.in_valid = 1'b0;
        #1;
        tb_wr    = tb_wr + 5'd1;
        tb_phase = ~tb_phase;
    endtask

    // 17 MAC cycles, 2 drain cycles, then out_valid must rise.
    task automatic check_accum(input logic [4:0] newest);
        logic [4:0] ea;
        for (int j = 0; j < 17; j++) begin
            if (j < 16) ea = newest - 5'(2 * j);
            else        ea = newest - 5'd15;
            chk("mac_en",       bus_if.mac_en,    32'd1);
            chk("mac_clr",      bus_if.mac_clr,   (j == 0) ? 32'd1 : 32'd0);
            chk("mac_raddr",    bus_if.buf_raddr, ea);
            chk("mac_coef",     bus_if.coef_addr, j);
            chk("mac_in_ready", bus_if.in_ready,  32'd0);
            chk("mac_we",       bus_if.buf_we,    32'd0);
            tick();
        end
        chk("drain0_mac_en",    bus_if.mac_en,    32'd0);
        chk("drain0_out_valid", bus_if.out_valid, 32'd0);
        tick();
        chk("drain1_mac_en",    bus_if.mac_en,    32'd0);
        chk("drain1_out_valid", bus_if.out_valid, 32'd0);
        tick();
        chk("out_latency",      bus_if.out_valid, 32'd1);
    endtask

    task automatic handshake();
        bus_if.out_ready = 1'b1;
        #1;
        chk("hs_out_valid", bus_if.out_valid, 32'd1);
        tick();
        bus_if.out_ready = 1'b0;
        #1;
        chk("hs_out_drop", bus_if.out_valid, 32'd0);
        chk("hs_in_ready", bus_if.in_ready,  32'd1);
        chk("hs_busy",     bus_if.busy,      32'd0);
    endtask

    initial begin
        int nout;
        int nacc;
        int last;

        // Reset held: registered outputs at their reset values.
        reset            = 1'b1;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        tick();
        tick();
        tick();
        chk("rst_mac_en",    bus_if.mac_en,    32'd0);
        chk("rst_mac_clr",   bus_if.mac_clr,   32'd0);
        chk("rst_out_valid", bus_if.out_valid, 32'd0);
        chk("rst_raddr",     bus_if.buf_raddr, 32'd0);
        chk("rst_coef",      bus_if.coef_addr, 32'd0);
        chk("rst_in_ready",  bus_if.in_ready,  32'd0);
        chk("rst_busy",      bus_if.busy,      32'd1);
        reset = 1'b0;
        run_init();

        // First pair: addresses 0,1; raddr 1,31,...,3 then 18.
        accept();
        accept();
        check_accum(5'd1);

        // Sink stalls 10 cycles; source pushes but nothing is written.
        bus_if.in_valid = 1'b1;
        #1;
        for (int c = 0; c < 10; c++) begin
            chk("hold_out_valid", bus_if.out_valid, 32'd1);
            chk("hold_in_ready",  bus_if.in_ready,  32'd0);
            chk("hold_we",        bus_if.buf_we,    32'd0);
            tick();
        end
        bus_if.in_valid = 1'b0;
        #1;
        chk("hold_out_valid", bus_if.out_valid, 32'd1);
        chk("hold_we",        bus_if.buf_we,    32'd0);
        handshake();

        // 40 samples with idle gaps; write pointer wraps 31 -> 0.
        for (int s = 0; s < 40; s++) begin
            accept();
            if (tb_phase == 1'b0) begin
                check_accum(tb_wr - 5'd1);
                handshake();
            end
            for (int g = 0; g < (s % 3); g++) begin
                chk("gap_we", bus_if.buf_we, 32'd0);
                tick();
            end
        end
        chk("wrap_ptr", tb_wr, 32'd10);

        // Reset in the middle of ACCUM at j=5.
        accept();
        accept();
        for (int j = 0; j < 5; j++) tick();
        chk("j5_raddr",  bus_if.buf_raddr, 32'd1);
        chk("j5_mac_en", bus_if.mac_en,    32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_mac_en",    bus_if.mac_en,    32'd0);
        chk("abort_out_valid", bus_if.out_valid, 32'd0);
        chk("abort_in_ready",  bus_if.in_ready,  32'd0);
        chk("abort_busy",      bus_if.busy,      32'd1);
        chk("abort_raddr",     bus_if.buf_raddr, 32'd0);
        chk("abort_coef",      bus_if.coef_addr, 32'd0);
        run_init();
        for (int k = 0; k < 25; k++) begin
            chk("abort_no_out", bus_if.out_valid, 32'd0);
            tick();
        end

        // Continuous streaming: 10 outputs, 22 cycles apart, 20 accepts.
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        nout = 0;
        nacc = 0;
        last = -1;
        for (int i = 0; i < 220; i++) begin
            #1;
            if (bus_if.out_valid === 1'b1) begin
                nout++;
                if (last >= 0) chk("stream_spacing", i - last, 32'd22);
                else           chk("stream_first",   i,        32'd21);
                last = i;
            end
            if (bus_if.in_ready === 1'b1) nacc++;
            tick();
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        chk("stream_outputs", nout, 32'd10);
        chk("stream_accepts", nacc, 32'd20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
